// File: rtl/lr_shift_cmd_fifo_if.sv
// lr_shift_cmd_fifo_if: command handshake bundle between producer, FIFO and shifter consumer
//   in_valid/in_ready/in_bits/in_shift/in_dir : producer command channel
//   out_valid/out_ready/iBits/shift/dir       : head command towards the shifter
//   count                                     : FIFO occupancy
interface lr_shift_cmd_fifo_if #(
  parameter int width = 8,
  parameter int depth = 4
);
  localparam int sw = $clog2(width);
  localparam int cw = $clog2(depth) + 1;
  logic          in_valid;
  logic          in_ready;
  logic [width-1:0] in_bits;
  logic [sw-1:0] in_shift;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [width-1:0] iBits;
  logic [sw-1:0] shift;
  logic          dir;
  logic [cw-1:0] count;
  modport master (
    output in_valid, in_bits, in_shift, in_dir, out_ready,
    input  in_ready, out_valid, iBits, shift, dir, count
  );
  modport slave (
    input  in_valid, in_bits, in_shift, in_dir, out_ready,
    output in_ready, out_valid, iBits, shift, dir, count
  );
endinterface

// File: rtl/lr_shift_cmd_fifo.sv
// lr_shift_cmd_fifo: command FIFO feeding {bits, shift, dir} to a left-right shifter
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : lr_shift_cmd_fifo_if.slave (command in, head out, count)
//   LR_SHIFT_CMD_FIFO_BYPASS_EN : when defined, an empty FIFO forwards in_* straight to the head
module lr_shift_cmd_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input logic clk,
  input logic rst,
  lr_shift_cmd_fifo_if.slave bus
);
  localparam int sw = $clog2(width);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam int ew = width + sw + 1;
  localparam logic [cw-1:0] full = cw'(depth);
  logic [ew-1:0] mem [depth];
  logic [ew-1:0] last, head, in_word;
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [cw-1:0] count;
  logic byp, push, pop, wr, rd;
  always_comb begin
    in_word = {bus.in_bits, bus.in_shift, bus.in_dir};
`ifdef LR_SHIFT_CMD_FIFO_BYPASS_EN
    byp = count == '0 && bus.in_valid;
`else
    byp = 1'b0;
`endif
    // when empty the head keeps showing the most recently consumed command
    head = byp ? in_word : (count != '0 ? mem[rd_ptr] : last);
    push = bus.in_valid && count != full;
    pop = (count != '0 || byp) && bus.out_ready;
    // a bypassed command that is consumed immediately is never stored
    wr = push && !(byp && bus.out_ready);
    rd = pop && count != '0;
  end
  assign bus.in_ready = count != full;
  assign bus.out_valid = count != '0 || byp;
  assign {bus.iBits, bus.shift, bus.dir} = head;
  assign bus.count = count;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      last <= '0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= in_word;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (pop) last <= head;
      count <= count + cw'(wr) - cw'(rd);
    end
  end
endmodule

// File: tb/tb_lr_shift_cmd_fifo.sv
// tb_lr_shift_cmd_fifo: directed scoreboard bench for lr_shift_cmd_fifo (width 8, depth 4)
module tb_lr_shift_cmd_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [11:0] sb [$];
  lr_shift_cmd_fifo_if #(.width(8), .depth(4)) f();
  lr_shift_cmd_fifo #(.width(8), .depth(4)) dut (.clk(clk), .rst(rst), .bus(f.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  // monitor: every consumed head must match the oldest expected command
  always @(negedge clk) begin
    if (!rst && f.out_valid && f.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head_unexpected actual=%0h expected=none", {f.iBits, f.shift, f.dir});
      end else begin
        chk("head", {20'd0, f.iBits, f.shift, f.dir}, {20'd0, sb.pop_front()});
      end
    end
  end
  task automatic step(input logic iv, input logic [7:0] b, input logic [2:0] s, input logic d,
                      input logic ordy, input logic acc);
    f.in_valid = iv;
    f.in_bits = b;
    f.in_shift = s;
    f.in_dir = d;
    f.out_ready = ordy;
    if (acc) sb.push_back({b, s, d});
    @(negedge clk);
    if (iv) chk("in_ready", {31'd0, f.in_ready}, {31'd0, acc});
    @(posedge clk);
    #1;
  endtask
  initial begin
    f.in_valid = 1'b0;
    f.in_bits = '0;
    f.in_shift = '0;
    f.in_dir = 1'b0;
    f.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, f.out_valid}, 0);
    chk("rst_in_ready", {31'd0, f.in_ready}, 1);
    chk("rst_count", {29'd0, f.count}, 0);
    chk("rst_ibits", {24'd0, f.iBits}, 0);
    for (int i = 0; i < 3; i++) step(1, 8'(8'hE0 + i), 3'(i), 1, 0, 1);
    chk("pre_rst_count", {29'd0, f.count}, 3);
    rst = 1'b1;
    f.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_count", {29'd0, f.count}, 0);
    chk("mid_rst_out_valid", {31'd0, f.out_valid}, 0);
    chk("mid_rst_ibits", {24'd0, f.iBits}, 0);
    step(1, 8'hA5, 3, 0, 0, 1);
    chk("single_valid", {31'd0, f.out_valid}, 1);
    chk("single_head", {20'd0, f.iBits, f.shift, f.dir}, {20'd0, 8'hA5, 3'd3, 1'b0});
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 0, 0, 0, 0);
      chk("hold_head", {20'd0, f.iBits, f.shift, f.dir}, {20'd0, 8'hA5, 3'd3, 1'b0});
    end
    step(0, 8'h00, 0, 0, 1, 0);
    chk("single_count", {29'd0, f.count}, 0);
    chk("empty_last_ibits", {24'd0, f.iBits}, 32'hA5);
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 3'(i), 0, 0, 1);
    chk("full_count", {29'd0, f.count}, 4);
    chk("full_in_ready", {31'd0, f.in_ready}, 0);
    step(1, 8'h05, 0, 0, 0, 0);
    chk("full_count_after_5th", {29'd0, f.count}, 4);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 1, 0);
    chk("drain_count", {29'd0, f.count}, 0);
    for (int i = 0; i < 10; i++) step(1, 8'(8'h10 + i), 3'(i % 8), 1'(i % 2), 1, 1);
    step(0, 8'h00, 0, 0, 1, 0);
    chk("wrap_count", {29'd0, f.count}, 0);
    step(1, 8'h31, 1, 0, 0, 1);
    step(1, 8'h32, 2, 1, 0, 1);
    step(1, 8'h33, 4, 0, 1, 1);
    chk("pushpop2_count", {29'd0, f.count}, 2);
    repeat (2) step(0, 8'h00, 0, 0, 1, 0);
    step(1, 8'h77, 5, 1, 1, 1);
`ifdef LR_SHIFT_CMD_FIFO_BYPASS_EN
    chk("pushpop0_count", {29'd0, f.count}, 0);
`else
    chk("pushpop0_count", {29'd0, f.count}, 1);
`endif
    step(0, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 3'(i % 8), 0, 1, 1);
      chk("stream_count_le1", {31'd0, f.count <= 1}, 1);
    end
    step(0, 8'h00, 0, 0, 1, 0);
    chk("final_count", {29'd0, f.count}, 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lr_shift_cmd_fifo.md
# lr_shift_cmd_fifo

Command queue directly upstream of the left-right bits shifter. It accepts shift commands, each a bits word plus shift amount plus direction, on a valid/ready interface. It buffers them in a small FIFO and presents the head command on the shifter's `iBits`/`shift`/`dir` inputs. The consumer pops the head with `out_ready` once the shifter result has been taken.

## Interface
- `width`, 8, width of bits word (≥2)
- `depth`, 4, FIFO entries (power of 2, ≥2)

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  producer has a command
- `in_ready`  out  1  FIFO can accept; `count < depth`
- `in_bits`  in  width  command bits word
- `in_shift`  in  clog2(width)  command shift amount
- `in_dir`  in  1  command direction; 0 = left, 1 = right (ShiftDir encoding)
- `out_valid`  out  1  head command present on shifter inputs
- `out_ready`  in  1  consumer pops head this cycle
- `iBits`  out  width  head bits word, to shifter `iBits`
- `shift`  out  clog2(width)  head shift amount, to shifter `shift`
- `dir`  out  1  head direction, to shifter `dir`
- `count`  out  clog2(depth)+1  current occupancy

## Operation
- Storage: `depth` entries of {bits, shift, dir}, with `wr_ptr`/`rd_ptr` of clog2(depth) bits.
  - Pointers wrap modulo `depth` (natural overflow).
  - `count` is a separate register.
- Push occurs when `in_valid && in_ready`. The entry is written at `wr_ptr`, then `wr_ptr` increments.
- Pop occurs when `out_valid && out_ready`, then `rd_ptr` increments.
- `out_valid = (count != 0)`.
- `iBits`/`shift`/`dir` = entry at `rd_ptr`.
  - They are held stable while `out_valid && !out_ready`.
  - When `count == 0` they show the last-read entry. After reset they show all zeros.
- Simultaneous push and pop:
  - `count` is unchanged.
  - When full, `in_ready` = 0, so no push that cycle even if a pop occurs. There is no full-pass-through.
  - When empty, the pop is ignored because `out_valid` = 0.
- `in_ready` depends only on registered `count`. There is no combinational path `out_ready` → `in_ready`.
- `in_*` values with `in_valid` = 0 are ignored. Shift value is not range-checked; it is passed through as-is.
- Reset:
  - `wr_ptr` = `rd_ptr` = 0 and `count` = 0.
  - Storage is cleared to 0.
  - `out_valid` = 0 and `in_ready` = 1.
  - `iBits`/`shift`/`dir` = 0.
  - Reset mid-operation discards all queued commands. A handshake in the reset cycle has no effect.
- No state machine beyond pointer/count.
  - States: EMPTY (`count` = 0), PARTIAL, FULL (`count` = `depth`).
  - Transitions are ±1 per cycle per push/pop rules above.

## Timing
- Push-to-`out_valid` latency: 1 cycle. A command pushed in cycle N is visible on `iBits`/`shift`/`dir` with `out_valid` = 1 in cycle N+1.
- Throughput: 1 command/cycle sustained when `out_ready` = 1 and `count` < `depth`.
- Head change after pop: the next entry appears in the cycle after the pop edge.
- Shifter is combinational; downstream samples its `oBits` in the same cycle it asserts `out_ready`.

## Configuration
- `LR_SHIFT_CMD_FIFO_BYPASS_EN` defined:
  - When `count` = 0 and `in_valid` = 1, `out_valid` = 1 combinationally.
  - `iBits`/`shift`/`dir` are driven straight from `in_bits`/`in_shift`/`in_dir`.
  - If `out_ready` = 1 in that cycle, the command is consumed without being written. `count`, `wr_ptr` and `rd_ptr` are unchanged.
  - Otherwise it is written as a normal push.
  - Latency in the empty case becomes 0 cycles. `in_ready` is unchanged (registered).
- Undefined: no combinational in→out path. Latency is always 1 cycle, as in Timing.

## Test plan
- Reset then idle:
  - `out_valid` = 0, `in_ready` = 1, `count` = 0, `iBits` = 0x00.
  - Assert `rst` with 3 entries queued → next cycle `count` = 0 and `out_valid` = 0.
- Single command: push {0xA5, 3, 0} in cycle 1 → cycle 2 `out_valid` = 1, `iBits` = 0xA5, `shift` = 3, `dir` = 0. Hold `out_ready` = 0 for 5 cycles → values stable. Pop → `count` = 0.
- Fill with `out_ready` = 0: push 0x01, 0x02, 0x03, 0x04 → `count` = 4, `in_ready` = 0. A 5th push of 0x05 is not accepted. Pop all → order 0x01..0x04.
- Wrap-around: 10 push/pop cycles with `depth` = 4, alternating `dir` 0/1 and `shift` 0..7 → output sequence equals input sequence. Pointers wrap with no loss.
- Simultaneous push+pop at `count` = 2 → `count` stays 2. Simultaneous push+pop at `count` = 0 → `count` becomes 1 (pop ignored), or under BYPASS_EN `count` stays 0 and the command appears in the same cycle.
- Streaming: `in_valid` = `out_ready` = 1 for 16 cycles with `in_bits` = cycle index → one output per cycle after 1-cycle latency (0 under BYPASS_EN). `count` ≤ 1.
